// File: rtl/adc_muestreo_ctrl.sv
// adc_muestreo_ctrl: paced serial ADC capture (CS/sclk generation, 16-bit shift-in)
// with a 12-bit valid/ack result and sticky overrun.
module adc_muestreo_ctrl #(
    parameter int DIV_SCLK = 2,
    parameter int PERIOD   = 2083
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sdata,
    output logic        cs,
    output logic        sclk,
    output logic [11:0] sample,
    output logic        sample_valid,
    input  logic        sample_ack,
    output logic        overrun,
    output logic        busy
);
    localparam int CW = $clog2(PERIOD);
    localparam int HW = $clog2(2 * DIV_SCLK);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, QUIET} state_t;
    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hc, hc_n;
    logic [4:0]    bits, bits_n;
    logic [15:0]   frame, frame_n;
    logic          sclk_n, tick, load;
    assign tick = cnt == CW'(PERIOD - 1);
    assign load = state == SHIFT && bits == 5'd16;
    always_comb begin
        state_n = state;
        hc_n    = hc;
        bits_n  = bits;
        frame_n = frame;
        sclk_n  = sclk;
        case (state)
            IDLE: if (tick) begin
                state_n = SHIFT;
                hc_n    = '0;
                bits_n  = '0;
            end
            // one extra SHIFT cycle after the 16th rise keeps cs low 32*DIV_SCLK+1 cycles
            SHIFT: if (bits == 5'd16) begin
                state_n = DONE;
            end else if (hc == HW'(DIV_SCLK - 1)) begin
                hc_n   = '0;
                sclk_n = ~sclk;
                if (!sclk) begin
                    frame_n = {frame[14:0], sdata};
                    bits_n  = bits + 5'd1;
                end
            end else begin
                hc_n = hc + HW'(1);
            end
            DONE: begin
                state_n = QUIET;
                hc_n    = '0;
            end
            QUIET: begin
                state_n = hc == HW'(2 * DIV_SCLK - 1) ? IDLE : QUIET;
                hc_n    = hc + HW'(1);
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            hc           <= '0;
            bits         <= '0;
            frame        <= '0;
            cs           <= 1'b1;
            sclk         <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= (!enable || tick) ? '0 : cnt + CW'(1);
            hc           <= hc_n;
            bits         <= bits_n;
            frame        <= frame_n;
            cs           <= state_n != SHIFT;
            sclk         <= sclk_n;
            busy         <= state_n != IDLE;
            sample       <= load ? frame[11:0] : sample;
            sample_valid <= load | (sample_valid & ~sample_ack);
            overrun      <= overrun | (load & sample_valid & ~sample_ack);
        end
    end
endmodule

// File: tb/tb_adc_muestreo_ctrl.sv
// tb_adc_muestreo_ctrl: ADC serial model feeding a scoreboard, checked against a
// cycle-age reference of the sampling schedule and handshake rules.
module tb_adc_muestreo_ctrl;
    localparam int D = 2;
    localparam int PERIOD = 80;
    logic        clk = 1'b0;
    logic        reset, enable, sdata, sample_ack;
    logic        cs, sclk, sample_valid, overrun, busy;
    logic [11:0] sample;
    int          checks = 0, failures = 0;
    logic [15:0] words[$];
    logic [11:0] exp_q[$];
    logic [15:0] adc_word = '0;
    logic        adc_cs_q = 1'b1, adc_sclk_q = 1'b1;
    int          fcnt = 16;
    int          age = -1, cnt_m = 0, ev = 0, eo = 0, es = 0, deliveries = 0;

    adc_muestreo_ctrl #(.DIV_SCLK(D), .PERIOD(PERIOD)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sdata(sdata), .cs(cs), .sclk(sclk),
        .sample(sample), .sample_valid(sample_valid), .sample_ack(sample_ack),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    // ADC: on each sclk fall present the next frame bit, MSB first
    always @(posedge clk) begin
        #1;
        if (!cs && adc_cs_q) begin
            adc_word = words.size() != 0 ? words.pop_front() : 16'($urandom);
            exp_q.push_back(adc_word[11:0]);
            fcnt = 0;
        end
        if (!sclk && adc_sclk_q && fcnt < 16) begin
            sdata = adc_word[15 - fcnt];
            fcnt++;
        end
        adc_cs_q   = cs;
        adc_sclk_q = sclk;
    end

    // reference: age counts edges since frame start (-1 = idle)
    always @(posedge clk) begin
        logic pr, pa, pe, tk;
        int   ecs, esc;
        pr = reset; pa = sample_ack; pe = enable;
        #1;
        if (pr) begin
            cnt_m = 0; age = -1; ev = 0; eo = 0; es = 0;
            exp_q.delete();
        end else begin
            tk    = cnt_m == PERIOD - 1;
            cnt_m = pe ? (tk ? 0 : cnt_m + 1) : 0;
            if (age >= 0) age = (age == 34 * D + 1) ? -1 : age + 1;
            else if (tk) age = 0;
            if (age == 32 * D + 1) begin
                chk("scoreboard_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) es = exp_q.pop_front();
                chk("sclk_falls_per_frame", fcnt, 16);
                eo = eo | (ev & !pa);
                ev = 1;
                deliveries++;
            end else if (pa) begin
                ev = 0;
            end
        end
        ecs = (age >= 0 && age <= 32 * D) ? 0 : 1;
        esc = (age >= 0 && age <= 32 * D) ? (((age / D) % 2) == 0) : 1;
        chk("cs", cs, ecs);
        chk("sclk", sclk, esc);
        chk("busy", busy, age >= 0);
        chk("sample_valid", sample_valid, ev);
        chk("overrun", overrun, eo);
        chk("sample", sample, es);
    end

    task automatic wait_deliv(input int n);
        int b = 0;
        while (deliveries < n && b < 400) begin
            @(posedge clk); #2; b++;
        end
        chk("wait_delivery", deliveries >= n, 1);
    endtask

    task automatic wait_age(input int a);
        int b = 0;
        while (age != a && b < 400) begin
            @(posedge clk); #2; b++;
        end
        chk("wait_age", age, a);
    endtask

    task automatic wait_bit(input int k);
        int b = 0;
        while (!(age >= 0 && age <= 32 * D && fcnt == k) && b < 400) begin
            @(posedge clk); #2; b++;
        end
        chk("wait_bit", fcnt, k);
    endtask

    task automatic ack_pulse();
        @(posedge clk); #2; sample_ack = 1'b1;
        @(posedge clk); #2; sample_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sdata = 1'b0; sample_ack = 1'b0;
        words = '{16'h0A5C, 16'hF123, 16'($urandom), 16'($urandom), 16'h0111, 16'h0222};
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (100) @(posedge clk);
        #2 enable = 1'b1;
        wait_deliv(1);
        chk("first_sample", sample, 12'hA5C);
        ack_pulse();
        wait_deliv(2);
        chk("header_ignored", sample, 12'h123);
        ack_pulse();
        wait_deliv(3);
        wait_age(32 * D);
        sample_ack = 1'b1;
        @(posedge clk); #2; sample_ack = 1'b0;
        chk("coincident_valid", sample_valid, 1);
        chk("coincident_overrun", overrun, 0);
        ack_pulse();
        wait_deliv(6);
        chk("overrun_sample", sample, 12'h222);
        chk("overrun_flag", overrun, 1);
        ack_pulse();
        wait_bit(5);
        enable = 1'b0;
        wait_deliv(7);
        repeat (200) @(posedge clk);
        #2 chk("no_restart_busy", busy, 0);
        ack_pulse();
        enable = 1'b1;
        wait_bit(8);
        reset = 1'b1;
        @(posedge clk); #2; reset = 1'b0;
        chk("reset_mid_cs", cs, 1);
        chk("reset_mid_valid", sample_valid, 0);
        repeat (600) begin
            @(posedge clk); #2;
            sample_ack = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 199) == 0) enable = !enable;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
